// File: rtl/rr_stream_mux2.sv
// rr_stream_mux2 -- two-input, packet-aware round-robin stream selector
// with a single registered output stage.
//
// The arbiter grants one input per packet. It holds the grant from the
// first accepted beat through the beat carrying last=1. Between packets the
// priority pointer alternates, so two continuously valid sources send
// strictly alternating packets. The granted beat is captured into one output
// register, which gives one cycle of latency and one beat per cycle of
// throughput while out_ready stays high.
//
// Ports:
//   clk, rst_n             clock; asynchronous active-low reset
//   in0_data/valid/last    stream 0 beat in
//   in0_ready              stream 0 accept
//   in1_data/valid/last    stream 1 beat in
//   in1_ready              stream 1 accept
//   out_data/valid/last    registered beat out
//   out_src                source index of the registered beat
//   out_ready              downstream accept
//   locked                 arbiter is in the middle of a packet
module rr_stream_mux2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic             locked
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state;
  logic             prio;
  logic             held;

  logic             load;
  logic             g;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  logic [WIDTH-1:0] data_p1;
  logic             last_p1;
  logic             src_p1;
  logic             vld_p1;

  // Stage 0: arbitration and the 2:1 select.
  assign load = !vld_p1 || out_ready;

  // While LOCKED the grant comes only from the held register. This keeps
  // the input valids off the ready path for the rest of the packet.
  always_comb begin
    g = prio;
    if (state == LOCKED)
      g = held;
    else if (in0_valid && !in1_valid)
      g = 1'b0;
    else if (in1_valid && !in0_valid)
      g = 1'b1;
  end

  assign in0_ready = load && !g;
  assign in1_ready = load && g;
  assign accept    = g ? (in1_valid && in1_ready) : (in0_valid && in0_ready);

  // A true mux, so the non-granted input's data never reaches the output.
  assign sel_data = g ? in1_data : in0_data;
  assign sel_last = g ? in1_last : in0_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
      held  <= 1'b0;
    end else if (accept) begin
      if (sel_last) begin
        state <= IDLE;
        prio  <= !g;
      end else begin
        state <= LOCKED;
        held  <= g;
      end
    end
  end

  // Stage 1: output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      src_p1  <= 1'b0;
    end else if (load) begin
      vld_p1 <= accept;
      if (accept) begin
        data_p1 <= sel_data;
        last_p1 <= sel_last;
        src_p1  <= g;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign out_last  = last_p1;
  assign out_src   = src_p1;
  assign locked    = (state == LOCKED);

endmodule
